// File: rtl/countdown_sched.sv
// Shares one CW-bit down-counter among NREQ requesters; one owner at a time, one-cycle done on expiry.
// Define COUNTDOWN_SCHED_RR_EN for rotating priority; otherwise the lowest requesting index always wins.
module countdown_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   load_val,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic [CW-1:0]        cnt,
    output logic                 busy
);
    // state | meaning
    // IDLE  | no owner; arbitrate among pending requests
    // COUNT | owner holds the counter; decrement or abort
    // DONE  | one-cycle done pulse to the owner, grant still held

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   owner, owner_n, win;
    logic            found;
    logic [NREQ-1:0] grant_n, done_n;
    logic [CW-1:0]   cnt_n;

`ifdef COUNTDOWN_SCHED_RR_EN
    logic [IW-1:0]   ptr, ptr_n, owner_inc;

    assign owner_inc = (owner == IW'(NREQ-1)) ? '0 : owner + IW'(1);

    // Search order starts at ptr and wraps, so the last owner goes to the back of the line.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                win   = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end
`else
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[k]) begin
                found = 1'b1;
                win   = IW'(k);
            end
        end
    end
`endif

    always_comb begin
        state_n = state;
        owner_n = owner;
        grant_n = grant;
        done_n  = '0;
        cnt_n   = cnt;
`ifdef COUNTDOWN_SCHED_RR_EN
        ptr_n   = ptr;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = COUNT;
                    owner_n = win;
                    grant_n = NREQ'(1) << win;
                    cnt_n   = load_val[win*CW +: CW];
                end
            end
            COUNT: begin
                if (!req[owner]) begin
                    state_n = IDLE;
                    grant_n = '0;
`ifdef COUNTDOWN_SCHED_RR_EN
                    ptr_n   = owner_inc;
`endif
                end else if (cnt == '0) begin
                    state_n = DONE;
                    done_n  = grant;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                grant_n = '0;
`ifdef COUNTDOWN_SCHED_RR_EN
                ptr_n   = owner_inc;
`endif
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            grant <= '0;
            done  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
`ifdef COUNTDOWN_SCHED_RR_EN
            ptr   <= '0;
`endif
        end else begin
            state <= state_n;
            owner <= owner_n;
            grant <= grant_n;
            done  <= done_n;
            cnt   <= cnt_n;
            busy  <= (state_n != IDLE);
`ifdef COUNTDOWN_SCHED_RR_EN
            ptr   <= ptr_n;
`endif
        end
    end

endmodule

// File: tb/tb_countdown_sched.sv
// Self-checking bench for countdown_sched: per-cycle expected outputs and next stimulus are queued,
// then popped and compared one clock at a time. Honours COUNTDOWN_SCHED_RR_EN if defined.
module tb_countdown_sched;
    localparam int NREQ = 4;
    localparam int CW   = 4;
`ifdef COUNTDOWN_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [NREQ-1:0]  req;
    logic [NREQ*CW-1:0] load_val;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  done;
    logic [CW-1:0]    cnt;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] lv;
        logic [12:0] exp;
    } item_t;

    item_t sbq[$];

    countdown_sched #(.NREQ(NREQ), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .load_val (load_val),
        .grant    (grant),
        .done     (done),
        .cnt      (cnt),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {grant, done, cnt, busy} after the next edge, plus the stimulus to drive after that.
    function automatic void push(input logic r, input logic [3:0] rq, input logic [15:0] l,
                                 input logic [3:0] g, input logic [3:0] d, input logic [3:0] c,
                                 input logic b);
        item_t it;
        it.rst = r;
        it.req = rq;
        it.lv  = l;
        it.exp = {g, d, c, b};
        sbq.push_back(it);
    endfunction

    task automatic test_reset();
        item_t it;
        rst = 1'b1; req = 4'b0000; load_val = 16'h0000;
        push(1'b1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'd0, 1'b0);
        push(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'd0, 1'b0);
        push(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'd0, 1'b0);
        while (sbq.size() > 0) begin
            @(posedge clk); #1;
            it = sbq.pop_front();
            n_cmp++;
            if ({grant, done, cnt, busy} !== it.exp) begin
                n_err++;
                $display("FAIL reset: got g/d/c/b=%b expected %b", {grant, done, cnt, busy}, it.exp);
            end
            rst = it.rst; req = it.req; load_val = it.lv;
        end
    endtask

    task automatic test_single();
        item_t it;
        req = 4'b0001; load_val = 16'h0003;
        // load_val moves to 9 right after grant; the loaded 3 must stand
        push(1'b0, 4'b0001, 16'h0009, 4'b0001, 4'b0000, 4'd3, 1'b1);
        push(1'b0, 4'b0001, 16'h0009, 4'b0001, 4'b0000, 4'd2, 1'b1);
        push(1'b0, 4'b0001, 16'h0009, 4'b0001, 4'b0000, 4'd1, 1'b1);
        push(1'b0, 4'b0001, 16'h0009, 4'b0001, 4'b0000, 4'd0, 1'b1);
        push(1'b0, 4'b0000, 16'h0009, 4'b0001, 4'b0001, 4'd0, 1'b1);
        push(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'd0, 1'b0);
        push(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'd0, 1'b0);
        while (sbq.size() > 0) begin
            @(posedge clk); #1;
            it = sbq.pop_front();
            n_cmp++;
            if ({grant, done, cnt, busy} !== it.exp) begin
                n_err++;
                $display("FAIL single: got g/d/c/b=%b expected %b", {grant, done, cnt, busy}, it.exp);
            end
            rst = it.rst; req = it.req; load_val = it.lv;
        end
    endtask

    task automatic test_zero_len();
        item_t it;
        req = 4'b0100; load_val = 16'h50A7;
        push(1'b0, 4'b0100, 16'h50A7, 4'b0100, 4'b0000, 4'd0, 1'b1);
        push(1'b0, 4'b0000, 16'h50A7, 4'b0100, 4'b0100, 4'd0, 1'b1);
        push(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'd0, 1'b0);
        while (sbq.size() > 0) begin
            @(posedge clk); #1;
            it = sbq.pop_front();
            n_cmp++;
            if ({grant, done, cnt, busy} !== it.exp) begin
                n_err++;
                $display("FAIL zero_len: got g/d/c/b=%b expected %b", {grant, done, cnt, busy}, it.exp);
            end
            rst = it.rst; req = it.req; load_val = it.lv;
        end
    endtask

    task automatic test_fairness();
        item_t it;
        logic [3:0] m;
        logic [3:0] g;
        rst = 1'b1; req = 4'b0000; load_val = 16'h1111;
        m = 4'b1111;
        push(1'b0, m, 16'h1111, 4'b0000, 4'b0000, 4'd0, 1'b0);
        for (int i = 0; i < NREQ; i++) begin
            g = 4'b0001 << i;
            push(1'b0, m, 16'h1111, g, 4'b0000, 4'd1, 1'b1);
            push(1'b0, m, 16'h1111, g, 4'b0000, 4'd0, 1'b1);
            m = m & ~g;
            push(1'b0, m, 16'h1111, g, g, 4'd0, 1'b1);
            push(1'b0, m, 16'h1111, 4'b0000, 4'b0000, 4'd0, 1'b0);
        end
        while (sbq.size() > 0) begin
            @(posedge clk); #1;
            it = sbq.pop_front();
            n_cmp++;
            if ({grant, done, cnt, busy} !== it.exp) begin
                n_err++;
                $display("FAIL fairness: got g/d/c/b=%b expected %b", {grant, done, cnt, busy}, it.exp);
            end
            rst = it.rst; req = it.req; load_val = it.lv;
        end
    endtask

    // req=0011 held through done: late drop re-requests; RR alternates, fixed priority keeps index 0
    task automatic test_late_drop();
        item_t it;
        logic [3:0] w;
        logic [3:0] rq;
        req = 4'b0011; load_val = 16'h0000;
        for (int s = 0; s < 3; s++) begin
            w  = (RR && s == 1) ? 4'b0010 : 4'b0001;
            rq = (s == 2) ? 4'b0000 : 4'b0011;
            push(1'b0, 4'b0011, 16'h0000, w, 4'b0000, 4'd0, 1'b1);
            push(1'b0, rq, 16'h0000, w, w, 4'd0, 1'b1);
            push(1'b0, rq, 16'h0000, 4'b0000, 4'b0000, 4'd0, 1'b0);
        end
        while (sbq.size() > 0) begin
            @(posedge clk); #1;
            it = sbq.pop_front();
            n_cmp++;
            if ({grant, done, cnt, busy} !== it.exp) begin
                n_err++;
                $display("FAIL late_drop: got g/d/c/b=%b expected %b", {grant, done, cnt, busy}, it.exp);
            end
            rst = it.rst; req = it.req; load_val = it.lv;
        end
    endtask

    task automatic test_abort();
        item_t it;
        req = 4'b0110; load_val = 16'h0290;
        for (int c = 9; c > 5; c--)
            push(1'b0, 4'b0110, 16'h0290, 4'b0010, 4'b0000, 4'(c), 1'b1);
        push(1'b0, 4'b0100, 16'h0290, 4'b0010, 4'b0000, 4'd5, 1'b1);
        push(1'b0, 4'b0100, 16'h0290, 4'b0000, 4'b0000, 4'd5, 1'b0);
        push(1'b0, 4'b0100, 16'h0290, 4'b0100, 4'b0000, 4'd2, 1'b1);
        push(1'b0, 4'b0100, 16'h0290, 4'b0100, 4'b0000, 4'd1, 1'b1);
        push(1'b0, 4'b0100, 16'h0290, 4'b0100, 4'b0000, 4'd0, 1'b1);
        push(1'b0, 4'b0000, 16'h0290, 4'b0100, 4'b0100, 4'd0, 1'b1);
        push(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'd0, 1'b0);
        while (sbq.size() > 0) begin
            @(posedge clk); #1;
            it = sbq.pop_front();
            n_cmp++;
            if ({grant, done, cnt, busy} !== it.exp) begin
                n_err++;
                $display("FAIL abort: got g/d/c/b=%b expected %b", {grant, done, cnt, busy}, it.exp);
            end
            rst = it.rst; req = it.req; load_val = it.lv;
        end
    endtask

    // Reset at cnt=7, then req=1001: index 0 must win again because ptr is back at 0
    task automatic test_reset_mid();
        item_t it;
        req = 4'b0001; load_val = 16'h000F;
        for (int c = 15; c > 7; c--)
            push(1'b0, 4'b0001, 16'h000F, 4'b0001, 4'b0000, 4'(c), 1'b1);
        push(1'b1, 4'b1001, 16'h000F, 4'b0001, 4'b0000, 4'd7, 1'b1);
        push(1'b0, 4'b1001, 16'h000F, 4'b0000, 4'b0000, 4'd0, 1'b0);
        push(1'b0, 4'b1000, 16'h000F, 4'b0001, 4'b0000, 4'd15, 1'b1);
        push(1'b0, 4'b1000, 16'h000F, 4'b0000, 4'b0000, 4'd15, 1'b0);
        push(1'b0, 4'b1000, 16'h000F, 4'b1000, 4'b0000, 4'd0, 1'b1);
        push(1'b0, 4'b0000, 16'h000F, 4'b1000, 4'b1000, 4'd0, 1'b1);
        push(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'd0, 1'b0);
        while (sbq.size() > 0) begin
            @(posedge clk); #1;
            it = sbq.pop_front();
            n_cmp++;
            if ({grant, done, cnt, busy} !== it.exp) begin
                n_err++;
                $display("FAIL reset_mid: got g/d/c/b=%b expected %b", {grant, done, cnt, busy}, it.exp);
            end
            rst = it.rst; req = it.req; load_val = it.lv;
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        load_val = 16'h0000;
        test_reset();
        test_single();
        test_zero_len();
        test_fairness();
        test_late_drop();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
